// File: rtl/sram_like_resp.sv
// SRAM-like responder: accepts address phases onto a 1-cycle synchronous RAM and returns
// data_ok/rdata in request order. Define SRAM_RAND_STALL_EN to add LFSR-driven random stalls.
module sram_like_resp #(
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 2,
  parameter int DATA_DELAY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [2:0] INIT_CNT = 3'(DATA_DELAY - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_wr;
  logic [DEPTH-1:0] r_cap;
  logic [31:0]      r_data [DEPTH];
  logic [2:0]       r_cnt  [DEPTH];
  logic             r_cap_pend;
  logic [PTR_W-1:0] r_cap_idx;

  logic        w_stall;
  logic        w_addr_ok;
  logic        w_accept;
  logic        w_pop;
  logic        w_head_fwd;
  logic [31:0] w_head_data;
  logic        w_unused;

  assign w_unused = ^{size, addr[31:ADDR_W+2], addr[1:0]};

`ifdef SRAM_RAND_STALL_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_stall   = r_lfsr[0] & r_lfsr[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end
`else
  assign w_stall = 1'b0;
`endif

  // No bypass: a slot freed by this cycle's pop is only visible next cycle.
  assign w_addr_ok = ~reset & (r_count < CNT_W'(DEPTH)) & ~w_stall;
  assign w_accept  = req & w_addr_ok;

  always_comb begin
    ram_addr  = addr[ADDR_W+1:2];
    ram_wdata = wdata;
    if (w_accept) begin
      ram_en = 1'b1;
      ram_we = wr ? wstrb : 4'b0000;
    end else begin
      ram_en = 1'b0;
      ram_we = 4'b0000;
    end
  end

  // Head whose RAM data arrives this cycle is forwarded straight from ram_rdata.
  always_comb begin
    w_head_fwd = r_cap_pend & (r_cap_idx == r_head);
    if (r_cap[r_head]) begin
      w_head_data = r_data[r_head];
    end else if (r_wr[r_head]) begin
      w_head_data = 32'h0000_0000;
    end else begin
      w_head_data = ram_rdata;
    end
    w_pop = ~reset & ~w_stall & r_vld[r_head] & (r_cnt[r_head] == 3'd0)
          & (r_cap[r_head] | w_head_fwd);
  end

  assign addr_ok = w_addr_ok;
  assign data_ok = w_pop;
  assign rdata   = reset ? 32'h0000_0000 : w_head_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head     <= {PTR_W{1'b0}};
      r_tail     <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_vld      <= {DEPTH{1'b0}};
      r_wr       <= {DEPTH{1'b0}};
      r_cap      <= {DEPTH{1'b0}};
      r_cap_pend <= 1'b0;
      r_cap_idx  <= {PTR_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= 32'h0000_0000;
        r_cnt[i]  <= 3'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i] && (r_cnt[i] != 3'd0)) begin
          r_cnt[i] <= r_cnt[i] - 3'd1;
        end
      end
      if (r_cap_pend) begin
        r_data[r_cap_idx] <= r_wr[r_cap_idx] ? 32'h0000_0000 : ram_rdata;
        r_cap[r_cap_idx]  <= 1'b1;
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= ptr_inc(r_head);
      end
      // The push slot never equals the capture slot, so push ordering here is safe.
      if (w_accept) begin
        r_vld[r_tail]  <= 1'b1;
        r_wr[r_tail]   <= wr;
        r_cap[r_tail]  <= 1'b0;
        r_data[r_tail] <= 32'h0000_0000;
        r_cnt[r_tail]  <= INIT_CNT;
        r_tail         <= ptr_inc(r_tail);
      end
      r_cap_pend <= w_accept;
      r_cap_idx  <= r_tail;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: two instances (DATA_DELAY 1 and 3) over write-first RAM models,
// checked against an in-order scoreboard fed from a shadow memory.
module tb_sram_like_resp;

  localparam int AW       = 8;
  localparam int DEP      = 2;
  localparam int NUM_RAND = 1000;

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req [2];
  logic        wr [2];
  logic [1:0]  size [2];
  logic [31:0] addr [2];
  logic [3:0]  wstrb [2];
  logic [31:0] wdata [2];
  logic        addr_ok [2];
  logic        data_ok [2];
  logic [31:0] rdata [2];
  logic        ram_en [2];
  logic [3:0]  ram_we [2];
  logic [AW-1:0] ram_addr [2];
  logic [31:0] ram_wdata [2];
  logic [31:0] ram_rdata [2];

  logic [31:0] mem [2][256];
  logic [31:0] shadow [2][256];
  sb_t         sbq [2][$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          acc_cnt [2];
  logic        seen_aok_low = 1'b0;
  logic        seen_dok_low = 1'b0;
  logic [31:0] ram_m;
  logic [31:0] mon_m;
  logic [31:0] mon_e;
  logic        mon_elig;
  logic        mon_room;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sram_like_resp #(.ADDR_W(AW), .DEPTH(DEP), .DATA_DELAY(1)) u_dut_d1 (
    .clk(clk), .reset(reset), .req(req[0]), .wr(wr[0]), .size(size[0]), .addr(addr[0]),
    .wstrb(wstrb[0]), .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]),
    .rdata(rdata[0]), .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
    .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
  );

  sram_like_resp #(.ADDR_W(AW), .DEPTH(DEP), .DATA_DELAY(3)) u_dut_d3 (
    .clk(clk), .reset(reset), .req(req[1]), .wr(wr[1]), .size(size[1]), .addr(addr[1]),
    .wstrb(wstrb[1]), .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]),
    .rdata(rdata[1]), .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
    .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int dd_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    req[k]   = r;
    wr[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
    wstrb[k] = s;
    size[k]  = 2'd2;
  endtask

  // Write-first synchronous RAM models with one cycle of read latency.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_en[k]) begin
        ram_m = mem[k][ram_addr[k]];
        for (int b = 0; b < 4; b++) begin
          if (ram_we[k][b]) ram_m[8*b +: 8] = ram_wdata[k][8*b +: 8];
        end
        mem[k][ram_addr[k]] = ram_m;
        ram_rdata[k] <= ram_m;
      end
    end
  end

  // Scoreboard monitor: push expectations on accept, compare and pop on data_ok.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        sbq[k].delete();
        chk("rst_dok", 32'(data_ok[k]), 32'd0);
      end else begin
        mon_elig = 1'b0;
        if (sbq[k].size() > 0) mon_elig = (cyc >= sbq[k][0].acc + dd_of(k));
        mon_room = (sbq[k].size() < DEP);
`ifdef SRAM_RAND_STALL_EN
        chk("dok_gate", 32'(data_ok[k] & ~mon_elig), 32'd0);
        chk("aok_gate", 32'(addr_ok[k] & ~mon_room), 32'd0);
        if (!data_ok[k] && mon_elig) seen_dok_low = 1'b1;
        if (!addr_ok[k] && mon_room) seen_aok_low = 1'b1;
`else
        chk("dok_time", 32'(data_ok[k]), 32'(mon_elig));
        chk("aok_room", 32'(addr_ok[k]), 32'(mon_room));
`endif
        if (data_ok[k] && (sbq[k].size() > 0)) begin
          chk("rdata", rdata[k], sbq[k][0].exp);
          void'(sbq[k].pop_front());
        end
        if (req[k] && addr_ok[k]) begin
          chk("ram_en", 32'(ram_en[k]), 32'd1);
          chk("ram_addr", 32'(ram_addr[k]), 32'(addr[k][9:2]));
          chk("ram_we", 32'(ram_we[k]), wr[k] ? 32'(wstrb[k]) : 32'd0);
          chk("ram_wdata", ram_wdata[k], wdata[k]);
          if (wr[k]) begin
            mon_m = shadow[k][addr[k][9:2]];
            for (int b = 0; b < 4; b++) begin
              if (wstrb[k][b]) mon_m[8*b +: 8] = wdata[k][8*b +: 8];
            end
            shadow[k][addr[k][9:2]] = mon_m;
            mon_e = 32'd0;
          end else begin
            mon_e = shadow[k][addr[k][9:2]];
          end
          sbq[k].push_back('{exp: mon_e, acc: cyc});
          acc_cnt[k]++;
        end else begin
          chk("ram_idle", 32'({ram_en[k], ram_we[k]}), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [7:0]  aok_tab;
    logic [7:0]  dok_tab;
    int          nacc;
    int          ndok;
    int          first_dok;
    int          last_dok;
    logic        rand_done;

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) begin
        mem[k][i]    = 32'hA500_0000 | (32'(k) << 16) | 32'(i);
        shadow[k][i] = 32'hA500_0000 | (32'(k) << 16) | 32'(i);
      end
      acc_cnt[k] = 0;
      drive(k, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0);
    end

    // Reset held with req high.
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("rst_aok", 32'(addr_ok[k]), 32'd0);
        chk("rst_rdata", rdata[k], 32'd0);
        chk("rst_ram_en", 32'(ram_en[k]), 32'd0);
      end
    end
    tick();
    reset = 1'b0;
    req[0] = 1'b0;
    req[1] = 1'b0;

`ifndef SRAM_RAND_STALL_EN
    // Write then read of the same word on the DATA_DELAY=1 instance.
    tick();
    drive(0, 1'b1, 1'b1, 32'h1C00_0010, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    chk("wr_aok", 32'(addr_ok[0]), 32'd1);
    chk("wr_ram_we", 32'(ram_we[0]), 32'h0000_000F);
    chk("wr_ram_addr", 32'(ram_addr[0]), 32'd4);
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    chk("wr_dok", 32'(data_ok[0]), 32'd1);
    chk("wr_rdata", rdata[0], 32'd0);
    tick();
    drive(0, 1'b1, 1'b0, 32'h1C00_0010, 32'h0000_0000, 4'h0);
    @(negedge clk);
    chk("rd_aok", 32'(addr_ok[0]), 32'd1);
    chk("rd_ram_we", 32'(ram_we[0]), 32'd0);
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    chk("rd_dok", 32'(data_ok[0]), 32'd1);
    chk("rd_rdata", rdata[0], 32'hDEAD_BEEF);

    // Full queue on the DATA_DELAY=3 instance: no bypass on pop.
    aok_tab = 8'b0001_0011;
    dok_tab = 8'b1001_1000;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      drive(1, (nacc < 3), 1'b0, 32'(nacc * 4), 32'h0000_0000, 4'h0);
      @(negedge clk);
      chk($sformatf("full_acc%0d", i), 32'(req[1] & addr_ok[1]), 32'(aok_tab[i]));
      chk($sformatf("full_dok%0d", i), 32'(data_ok[1]), 32'(dok_tab[i]));
      if (req[1] && addr_ok[1]) nacc++;
    end
    tick();
    req[1] = 1'b0;

    // Back-to-back reads at full throughput on the DATA_DELAY=1 instance.
    nacc = 0;
    ndok = 0;
    first_dok = -1;
    last_dok = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      drive(0, (nacc < 8), 1'b0, 32'(nacc * 4), 32'h0000_0000, 4'h0);
      @(negedge clk);
      if (data_ok[0]) begin
        ndok++;
        if (first_dok < 0) first_dok = cyc;
        last_dok = cyc;
      end
      if (req[0] && addr_ok[0]) nacc++;
    end
    chk("b2b_acc", 32'(nacc), 32'd8);
    chk("b2b_dok", 32'(ndok), 32'd8);
    chk("b2b_span", 32'(last_dok - first_dok), 32'd7);
    tick();
    req[0] = 1'b0;

    // Reset with two outstanding reads on the DATA_DELAY=3 instance.
    drive(1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0);
    @(negedge clk);
    chk("rst2_acc0", 32'(addr_ok[1]), 32'd1);
    tick();
    drive(1, 1'b1, 1'b0, 32'h0000_0044, 32'h0000_0000, 4'h0);
    @(negedge clk);
    chk("rst2_acc1", 32'(addr_ok[1]), 32'd1);
    tick();
    req[1] = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst2_dok_in", 32'(data_ok[1]), 32'd0);
      tick();
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("rst2_dok_after", 32'(data_ok[1]), 32'd0);
      tick();
    end
    drive(1, 1'b1, 1'b0, 32'h0000_0048, 32'h0000_0000, 4'h0);
    @(negedge clk);
    chk("rst2_acc_new", 32'(addr_ok[1]), 32'd1);
    for (int j = 1; j <= 3; j++) begin
      tick();
      req[1] = 1'b0;
      @(negedge clk);
      chk($sformatf("rst2_lat%0d", j), 32'(data_ok[1]), 32'(j == 3));
    end
`endif

    // Random mixed traffic on both instances.
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    rand_done = 1'b0;
    for (int it = 0; (it < 20000) && !rand_done; it++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (acc_cnt[k] < NUM_RAND) begin
          ra = $urandom();
          ra[9:2] = 8'($urandom_range(0, 15));
          drive(k, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra, $urandom(),
                4'($urandom_range(0, 15)));
        end else begin
          req[k] = 1'b0;
        end
      end
      rand_done = (acc_cnt[0] >= NUM_RAND) && (acc_cnt[1] >= NUM_RAND);
    end
    chk("rand_done", 32'(rand_done), 32'd1);
    req[0] = 1'b0;
    req[1] = 1'b0;
    for (int it = 0; (it < 50) && ((sbq[0].size() + sbq[1].size()) != 0); it++) begin
      tick();
    end
    chk("drain", 32'(sbq[0].size() + sbq[1].size()), 32'd0);
`ifdef SRAM_RAND_STALL_EN
    chk("aok_stall_seen", 32'(seen_aok_low), 32'd1);
    chk("dok_stall_seen", 32'(seen_dok_low), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
